// File: rtl/sram_in_rd_pkg.sv
`default_nettype none
// ============================================================
// Package : sram_in_rd_pkg
// Desc    : Shared types and constants for the input-SRAM read sequencer.
// Rev     : 1.0
// ============================================================
package sram_in_rd_pkg;

  localparam int SKID_DEPTH   = 2;
  localparam int SKID_CNT_W   = $clog2(SKID_DEPTH + 1);
  localparam int DEF_SRAM_BIT = 64;
  localparam int DEF_ADDR_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_in_rd_skid.sv
`default_nettype none
// ============================================================
// Module : sram_in_rd_skid
// Desc   : 2-entry skid FIFO with the head held in a register.
// Rev    : 1.0
// ============================================================
module sram_in_rd_skid
  import sram_in_rd_pkg::*;
#(
  parameter int W = DEF_SRAM_BIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_push,
  input  logic [W-1:0]          i_din,
  input  logic                  i_pop,
  output logic [W-1:0]          o_head,
  output logic [SKID_CNT_W-1:0] o_cnt
);

  logic [W-1:0]          r_head;
  logic [W-1:0]          r_tail;
  logic [SKID_CNT_W-1:0] r_cnt;

  // The head slot always holds the oldest word; the tail slot shifts in on pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == '0) r_head <= i_din;
          else             r_tail <= i_din;
          r_cnt <= r_cnt + 1'b1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 1'b1;
        end
        2'b11: begin
          if (r_cnt == SKID_CNT_W'(1)) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head = r_head;
  assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/sram_in_reader.sv
`default_nettype none
// ============================================================
// Module : sram_in_reader
// Desc   : Burst read sequencer for the input-activation SRAM feeding a
//          valid/ready stream through a skid buffer. Defining
//          SRAM_IN_RD_PERF_EN adds the stall_cnt back-pressure counter.
// Rev    : 1.0
// ============================================================
module sram_in_reader
  import sram_in_rd_pkg::*;
#(
  parameter int SRAM_BIT = DEF_SRAM_BIT,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W:0]     len,
  output logic                busy,
  output logic                done,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [ADDR_W-1:0]   sram_a,
  input  logic [SRAM_BIT-1:0] sram_q,
  output logic [SRAM_BIT-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
`ifdef SRAM_IN_RD_PERF_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  rd_state_e             r_state;
  rd_state_e             w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W:0]       r_rem;
  logic                  r_pend;
  logic [SKID_CNT_W-1:0] w_cnt;
  logic [ADDR_W:0]       w_len_clamped;
  logic [2:0]            w_occ;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_start_ok;

  assign w_len_clamped = (len > c_DEPTH) ? c_DEPTH : len;
  assign w_start_ok    = start && (r_state == ST_IDLE);
  assign out_valid     = (w_cnt != '0);
  assign w_pop         = out_valid && out_ready;

  // Occupancy after this cycle's pop, counting the word still in the SRAM pipe.
  assign w_occ    = 3'(w_cnt) + {2'b00, r_pend};
  assign w_credit = (w_occ - {2'b00, w_pop}) < 3'd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = (w_len_clamped == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (w_issue && (r_rem == (ADDR_W+1)'(1))) w_next = ST_DRAIN;
      ST_DRAIN: if (!r_pend && (w_cnt == SKID_CNT_W'(w_pop))) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != ST_IDLE);
    done     = (r_state == ST_DONE);
    w_issue  = (r_state == ST_READ) && (r_rem != '0) && w_credit;
    sram_cen = !w_issue;
  end

  assign sram_wen = 1'b1;
  assign sram_a   = r_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_start_ok) begin
        r_addr <= base;
        r_rem  <= w_len_clamped;
      end else if (w_issue) begin
        r_addr <= r_addr + 1'b1;
        r_rem  <= r_rem - 1'b1;
      end
    end
  end

  sram_in_rd_skid #(
    .W (SRAM_BIT)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_pend),
    .i_din   (sram_q),
    .i_pop   (w_pop),
    .o_head  (out_data),
    .o_cnt   (w_cnt)
  );

`ifdef SRAM_IN_RD_PERF_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                          r_stall <= '0;
    else if (w_start_ok)                                   r_stall <= '0;
    else if (out_valid && !out_ready && r_stall != 16'hFFFF) r_stall <= r_stall + 1'b1;
  end

  assign stall_cnt = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_in_reader.sv
`default_nettype none
// Self-checking bench for sram_in_reader: SRAM model, address/data scoreboard
// and cycle-level expectations derived from burst length and stall pattern.
module tb_sram_in_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  base = '0;
  logic [4:0]  len = '0;
  logic        busy, done, sram_cen, sram_wen, out_valid;
  logic [3:0]  sram_a;
  logic [63:0] sram_q = '0;
  logic [63:0] out_data;
  logic        out_ready = 1'b1;
`ifdef SRAM_IN_RD_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  logic [63:0] mem [16];
  logic [3:0]  addr_q [$];
  logic [63:0] data_q [$];
  logic [3:0]  rec_a [$];
  int          outstanding = 0;
  int          stall_model = 0;
  bit          prev_hold = 0;
  logic [63:0] prev_data = '0;

  always #5 clk = ~clk;

  sram_in_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_q    (sram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SRAM_IN_RD_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // SRAM with one-cycle registered read.
  always @(posedge clk) if (!sram_cen) sram_q <= mem[sram_a];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
  endtask

  function automatic logic rdy(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return !(t >= 4 && t <= 9);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Scoreboard: every read address, every accepted word, hold and credit rules.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 0;
    end else begin
      if (!sram_cen) begin
        rec_a.push_back(sram_a);
        if (addr_q.size() == 0) fail("extra_read");
        else chk("sram_a", sram_a, addr_q.pop_front());
        chk("credit", 64'((outstanding - int'(out_valid && out_ready)) < 2), 1);
        chk("wen", sram_wen, 1);
      end
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (data_q.size() == 0) fail("extra_word");
        else chk("out_data", out_data, data_q.pop_front());
      end
      if (out_valid && !out_ready) stall_model++;
      if (!sram_cen) outstanding++;
      if (out_valid && out_ready) outstanding--;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic burst(input logic [3:0] b, input logic [4:0] l, input int mode,
                       input int restart_at, output int done_at,
                       output int first_valid, output logic [63:0] first_data);
    int n;
    int t;
    n = (l > 5'd16) ? 16 : int'(l);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(4'(b + i));
      data_q.push_back(mem[4'(b + i)]);
    end
    rec_a.delete();
    done_at = -1;
    first_valid = -1;
    first_data = '0;
    t = 0;
    @(posedge clk); #1;
    start = 1'b1; base = b; len = l; out_ready = rdy(mode, 0);
    stall_model = 0;
    while (done_at < 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
      start = (t == restart_at);
      if (t == restart_at) begin
        base = b + 4'd5;
        len  = 5'd3;
      end
      out_ready = rdy(mode, t);
      @(negedge clk);
      if (out_valid && first_valid < 0) begin
        first_valid = t;
        first_data  = out_data;
      end
      if (done) done_at = t;
    end
    start = 1'b0;
    if (done_at < 0) fail("done_timeout");
    chk("drain_data", 64'(data_q.size()), 0);
    chk("drain_addr", 64'(addr_q.size()), 0);
    @(posedge clk); #1;
    chk("idle_after", busy, 0);
    chk("done_pulse", done, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_cen"}, sram_cen, 1);
    chk({tag, "_wen"}, sram_wen, 1);
    chk({tag, "_a"}, sram_a, 0);
    chk({tag, "_data"}, out_data, 0);
`ifdef SRAM_IN_RD_PERF_EN
    chk({tag, "_stall"}, stall_cnt, 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d, fv, n;
    logic [63:0] fd;
    logic [3:0]  exp_a [4];
    logic [3:0]  rb;
    logic [4:0]  rl;
    int          rm;

    exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
    for (int i = 0; i < 16; i++) mem[i] = 64'h1000 + 64'(i);

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset_n = 1'b1;

    // Full 16-word burst at full rate.
    burst(4'd0, 5'd16, 0, -1, d, fv, fd);
    chk("t1_done_cyc", 64'(d), 19);
    chk("t1_first_valid", 64'(fv), 3);
    chk("t1_first_data", fd, 64'h1000);

    // Address wrap-around.
    burst(4'd14, 5'd4, 0, -1, d, fv, fd);
    chk("t2_done_cyc", 64'(d), 7);
    chk("t2_nreads", 64'(rec_a.size()), 4);
    for (int k = 0; k < 4 && k < rec_a.size(); k++) chk("t2_addr", rec_a[k], exp_a[k]);
    chk("t2_first_data", fd, 64'h100E);

    // Back-pressure in cycles 4..9.
    burst(4'd0, 5'd8, 1, -1, d, fv, fd);
    chk("t3_done_cyc", 64'(d), 17);
`ifdef SRAM_IN_RD_PERF_EN
    chk("t3_stall", stall_cnt, 6);
`endif

    // Zero length, then clamped length.
    burst(4'd5, 5'd0, 0, -1, d, fv, fd);
    chk("t4_done_cyc", 64'(d), 1);
    chk("t4_nreads", 64'(rec_a.size()), 0);
    burst(4'd3, 5'd20, 0, -1, d, fv, fd);
    chk("t4b_done_cyc", 64'(d), 19);
    chk("t4b_nreads", 64'(rec_a.size()), 16);

    // Asynchronous reset in the cycle after the 5th read.
    for (int i = 0; i < 16; i++) begin
      addr_q.push_back(4'(i));
      data_q.push_back(mem[i]);
    end
    @(posedge clk); #1;
    start = 1'b1; base = 4'd0; len = 5'd16; out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    addr_q.delete();
    data_q.delete();
    outstanding = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    burst(4'd2, 5'd16, 0, -1, d, fv, fd);
    chk("t5_done_cyc", 64'(d), 19);
    chk("t5_first_data", fd, 64'h1002);

    // start while busy is ignored.
    burst(4'd3, 5'd6, 0, 2, d, fv, fd);
    chk("t6_done_cyc", 64'(d), 9);
    chk("t6_nreads", 64'(rec_a.size()), 6);

    // Randomized bursts with random data and back-pressure.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
      rb = 4'($urandom_range(0, 15));
      rl = 5'($urandom_range(0, 20));
      rm = (r % 3 == 0) ? 0 : 2;
      n  = (rl > 5'd16) ? 16 : int'(rl);
      burst(rb, rl, rm, -1, d, fv, fd);
      if (rm == 0) chk("rnd_done_cyc", 64'(d), (n == 0) ? 1 : 64'(n + 3));
      chk("rnd_nreads", 64'(rec_a.size()), 64'(n));
`ifdef SRAM_IN_RD_PERF_EN
      chk("rnd_stall", stall_cnt, 64'(stall_model));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_in_reader.md
# sram_in_reader

Read sequencer for the 16-entry, 64-bit input-activation SRAM. On a start command it issues a burst of single-cycle reads from a base address and accounts for the SRAM's one-cycle registered read latency. Each returned word is forwarded through a 2-entry skid buffer onto a valid/ready stream. The stream feeds the L0 input FIFO / systolic-array row loader, so downstream back-pressure never drops or duplicates a word.

## Interface
- `SRAM_BIT`, default 64: SRAM word width and stream data width.
- `ADDR_W`, default 4: SRAM address width; the SRAM depth is 2^ADDR_W = 16.
- `clk` in, 1: the single clock; all logic is on its rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: burst request; sampled only in IDLE.
- `base` in, ADDR_W: first address of the burst; sampled with `start`.
- `len` in, ADDR_W+1: number of words in the burst, 0..16; values above 16 are clamped to 16.
- `busy` out, 1: high in every state except IDLE.
- `done` out, 1: one-cycle pulse after the last word is accepted downstream.
- `sram_cen` out, 1: SRAM chip enable, active-low.
- `sram_wen` out, 1: SRAM write enable; always 1 (read-only master).
- `sram_a` out, ADDR_W: SRAM address.
- `sram_q` in, SRAM_BIT: SRAM read data, valid the cycle after a read is issued.
- `out_data` out, SRAM_BIT: stream data.
- `out_valid` out, 1: stream valid.
- `out_ready` in, 1: stream ready from the consumer.
- `stall_cnt` out, 16: present only with `SRAM_IN_RD_PERF_EN`.

## Operation
- States:
  - IDLE:
    - `start`=1 with clamped `len`=0 → DONE.
    - `start`=1 with `len`>0 → READ; `base` and `len` are latched and the remaining-count register is loaded.
  - READ: reads are issued under the credit rule; after the last read is issued → DRAIN.
  - DRAIN: waits until the in-flight flag is clear and the skid buffer is empty → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Credit rule: a read is issued in a cycle iff `cnt + pend - pop < 2`.
  - `cnt` is skid-buffer occupancy (0..2).
  - `pend` is the in-flight read flag.
  - `pop` is `out_valid & out_ready` in the same cycle.
  - The rule guarantees that the skid buffer never overflows.
- Issuing a read: `sram_cen`=0, `sram_a` = (base + issued) mod 16, and `pend` is set for the next cycle.
- In a cycle with `pend`=1, `sram_q` is pushed into the skid buffer at the end of that cycle.
- Addresses wrap: `base`=14 with `len`=4 reads addresses 14, 15, 0, 1.
- `out_data` is the skid-buffer head, held stable while `out_valid & !out_ready`; the head is popped on handshake.
- A simultaneous push and pop is legal; occupancy is unchanged.
- `start` while `busy` is ignored.
- Reset values, applied asynchronously at any point including mid-burst:
  - state = IDLE; `busy`=0, `done`=0, `out_valid`=0.
  - `sram_cen`=1, `sram_wen`=1, `sram_a`=0, `out_data`=0.
  - `cnt`=0, `pend`=0, `stall_cnt`=0.
  - Any in-flight data is discarded.

## Timing
- Cycle numbering: `start` is sampled at the end of cycle 0.
- First read: cycle 1, with `sram_cen` low and `sram_a`=`base`.
- First data: captured at the end of cycle 2; `out_valid` rises in cycle 3.
- Latency from `start` to first `out_valid` is 3 cycles.
- With `out_ready` held high, one read is issued every cycle and one word is output every cycle.
  - For `len`=16: reads occur in cycles 1–16, `out_valid` is high in cycles 3–18, `done` pulses in cycle 19, and the block is back in IDLE in cycle 20.
- `len`=0: `done` pulses in cycle 1 with no SRAM access.
- `sram_cen` is 1 whenever no read is issued.

## Configuration
- Macro: `SRAM_IN_RD_PERF_EN`.
- When defined:
  - `stall_cnt` increments in each cycle with `out_valid & !out_ready`.
  - It saturates at 0xFFFF and clears on an accepted `start`.
- When not defined:
  - The port and its counter are absent.
  - All other behaviour is identical.

## Structure
- Package `sram_in_rd_pkg`:
  - state enum (IDLE, READ, DRAIN, DONE);
  - `SKID_DEPTH`=2;
  - default `SRAM_BIT` and `ADDR_W` constants.
- Sub-module `sram_in_rd_skid`: 2-entry FIFO with push, pop, head, count and a registered head output.
- The top level holds the FSM, the address/count registers, the credit logic and the optional counter.

## Test plan
- `base`=0, `len`=16, `out_ready`=1, SRAM preloaded with word i = 64'h1000+i → 16 beats in cycles 3–18 with values 0x1000..0x100F in order, then `done` in cycle 19.
- `base`=14, `len`=4 → `sram_a` sequence 14, 15, 0, 1 and output words 14, 15, 0, 1.
- `out_ready` low in cycles 4–9 during a `len`=8 burst:
  - no SRAM read is issued while `cnt + pend` = 2;
  - `out_data` holds;
  - the sequence completes without loss or duplicates;
  - with the macro defined, `stall_cnt`=6.
- `len`=0, then `len`=20 → `done` in cycle 1 with `sram_cen` held at 1; the `len`=20 burst delivers exactly 16 words.
- `reset_n` asserted low in the cycle after the 5th read of a `len`=16 burst → all outputs reach their reset values immediately; a new `start` then runs a clean full burst.
- `start` pulsed again while `busy` → ignored, and the original burst completes unchanged.
